// File: rtl/uart_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : uart_result_monitor
//  Purpose  : Pops bytes from the bench UART receiver, collects them into a
//             line buffer and scans each line for the tokens "PASS" and
//             "FAIL", raising sticky verdict flags when a line terminates.
//  Ports    : ACLK/ARESET      clock, synchronous active-high reset
//             rx_data/rx_ready receiver byte and "byte available" level
//             rx_data_reg_rd   one-cycle pop strobe back to the receiver
//             line_valid       one-cycle pulse when a line terminates (LF)
//             line_len/trunc   length / overflow of the last terminated line
//             line_rd_idx/char registered read port into the line buffer
//             pass/fail/done   sticky verdicts
//             char_cnt/cnt     byte and line counters
//  Options  : UART_MON_CNT_EN  when defined, char_cnt/line_cnt are live
//             counters; otherwise they are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module uart_result_monitor #(
  parameter int LINE_MAX = 64,
  parameter int LW       = $clog2(LINE_MAX) + 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          rx_data_reg_rd,
  output logic          line_valid,
  output logic [LW-1:0] line_len,
  output logic          line_trunc,
  input  logic [LW-2:0] line_rd_idx,
  output logic [7:0]    line_rd_char,
  output logic          pass,
  output logic          fail,
  output logic          done,
  output logic [31:0]   char_cnt,
  output logic [15:0]   line_cnt
);

  localparam logic [1:0]    c_idle     = 2'd0;
  localparam logic [1:0]    c_capt     = 2'd1;
  localparam logic [1:0]    c_proc     = 2'd2;
  localparam logic [1:0]    c_eol      = 2'd3;
  localparam logic [7:0]    c_lf       = 8'h0A;
  localparam logic [7:0]    c_cr       = 8'h0D;
  localparam logic [31:0]   c_tok_pass = 32'h50415353;  // "PASS"
  localparam logic [31:0]   c_tok_fail = 32'h4641494C;  // "FAIL"
  localparam logic [LW-1:0] c_line_max = LW'(LINE_MAX);

  logic [1:0]    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic          trunc_q, trunc_d;
  logic [2:0]    p_idx_q, p_idx_d, f_idx_q, f_idx_d;
  logic          p_hit_q, p_hit_d, f_hit_q, f_hit_d;
  logic          line_valid_q, line_valid_d;
  logic [LW-1:0] line_len_q, line_len_d;
  logic          line_trunc_q, line_trunc_d;
  logic          pass_q, pass_d, fail_q, fail_d;
  logic [7:0]    line_rd_char_q, line_rd_char_d;
  logic          mem_we;
  logic [3:0]    p_step, f_step;
  logic [7:0]    line_mem [LINE_MAX];

  // One matcher step: returns {hit, next_idx}. On a mismatch the byte may
  // itself start a new match; the tokens never overlap themselves, so this
  // single-character restart is exact.
  function automatic logic [3:0] match_step(input logic [2:0]  idx,
                                            input logic [7:0]  b,
                                            input logic [31:0] tok);
    logic [7:0] exp_ch;
    logic [2:0] nxt;
    case (idx[1:0])
      2'd0:    exp_ch = tok[31:24];
      2'd1:    exp_ch = tok[23:16];
      2'd2:    exp_ch = tok[15:8];
      default: exp_ch = tok[7:0];
    endcase
    if (b == exp_ch)          nxt = idx + 3'd1;
    else if (b == tok[31:24]) nxt = 3'd1;
    else                      nxt = 3'd0;
    if (nxt == 3'd4) return {1'b1, 3'd0};
    return {1'b0, nxt};
  endfunction

  // ---------------------------------------------------------------- state
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q        <= c_idle;
      byte_q         <= '0;
      wr_ptr_q       <= '0;
      trunc_q        <= 1'b0;
      p_idx_q        <= '0;
      f_idx_q        <= '0;
      p_hit_q        <= 1'b0;
      f_hit_q        <= 1'b0;
      line_valid_q   <= 1'b0;
      line_len_q     <= '0;
      line_trunc_q   <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      line_rd_char_q <= '0;
    end else begin
      state_q        <= state_d;
      byte_q         <= byte_d;
      wr_ptr_q       <= wr_ptr_d;
      trunc_q        <= trunc_d;
      p_idx_q        <= p_idx_d;
      f_idx_q        <= f_idx_d;
      p_hit_q        <= p_hit_d;
      f_hit_q        <= f_hit_d;
      line_valid_q   <= line_valid_d;
      line_len_q     <= line_len_d;
      line_trunc_q   <= line_trunc_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      line_rd_char_q <= line_rd_char_d;
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) line_mem[wr_ptr_q[LW-2:0]] <= byte_q;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (rx_ready) state_d = c_capt;
      c_capt:  state_d = c_proc;
      c_proc:  state_d = (byte_q == c_lf) ? c_eol : c_idle;
      default: state_d = c_idle;
    endcase
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    rx_data_reg_rd = (state_q == c_capt);
  end

  // -------------------------------------------------------------- datapath
  always_comb begin
    byte_d         = byte_q;
    wr_ptr_d       = wr_ptr_q;
    trunc_d        = trunc_q;
    p_idx_d        = p_idx_q;
    f_idx_d        = f_idx_q;
    p_hit_d        = p_hit_q;
    f_hit_d        = f_hit_q;
    line_valid_d   = 1'b0;
    line_len_d     = line_len_q;
    line_trunc_d   = line_trunc_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    mem_we         = 1'b0;
    p_step         = match_step(p_idx_q, byte_q, c_tok_pass);
    f_step         = match_step(f_idx_q, byte_q, c_tok_fail);
    line_rd_char_d = line_mem[line_rd_idx];
    case (state_q)
      c_capt: byte_d = rx_data;
      c_proc: begin
        if (byte_q == c_cr) begin
          p_idx_d = '0;
          f_idx_d = '0;
        end else if (byte_q != c_lf) begin
          if (wr_ptr_q < c_line_max) begin
            mem_we   = ~ARESET;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          // Matchers still see bytes dropped by truncation.
          p_idx_d = p_step[2:0];
          f_idx_d = f_step[2:0];
          p_hit_d = p_hit_q | p_step[3];
          f_hit_d = f_hit_q | f_step[3];
        end
      end
      c_eol: begin
        line_valid_d = 1'b1;
        line_len_d   = wr_ptr_q;
        line_trunc_d = trunc_q;
        pass_d       = pass_q | p_hit_q;
        fail_d       = fail_q | f_hit_q;
        wr_ptr_d     = '0;
        trunc_d      = 1'b0;
        p_idx_d      = '0;
        f_idx_d      = '0;
        p_hit_d      = 1'b0;
        f_hit_d      = 1'b0;
      end
      default: ;
    endcase
  end

  assign line_valid   = line_valid_q;
  assign line_len     = line_len_q;
  assign line_trunc   = line_trunc_q;
  assign line_rd_char = line_rd_char_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign done         = pass_q | fail_q;

  // -------------------------------------------------------------- counters
`ifdef UART_MON_CNT_EN
  logic [31:0] char_cnt_q, char_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;

  always_comb begin
    char_cnt_d = char_cnt_q + ((state_q == c_capt) ? 32'd1 : 32'd0);
    line_cnt_d = line_cnt_q + ((state_q == c_eol)  ? 16'd1 : 16'd0);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      char_cnt_q <= '0;
      line_cnt_q <= '0;
    end else begin
      char_cnt_q <= char_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign char_cnt = char_cnt_q;
  assign line_cnt = line_cnt_q;
`else
  assign char_cnt = '0;
  assign line_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_result_monitor
//  Purpose  : Self-checking bench for uart_result_monitor. A receiver model
//             offers bytes and honours the pop strobe; a string-level
//             reference model predicts line length, truncation, verdicts,
//             buffer contents and counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_result_monitor;

  localparam int LINE_MAX = 64;
  localparam int LW       = $clog2(LINE_MAX) + 1;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_data_reg_rd;
  logic          line_valid;
  logic [LW-1:0] line_len;
  logic          line_trunc;
  logic [LW-2:0] line_rd_idx;
  logic [7:0]    line_rd_char;
  logic          pass, fail, done;
  logic [31:0]   char_cnt;
  logic [15:0]   line_cnt;

  uart_result_monitor #(.LINE_MAX(LINE_MAX)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_data_reg_rd(rx_data_reg_rd), .line_valid(line_valid),
    .line_len(line_len), .line_trunc(line_trunc), .line_rd_idx(line_rd_idx),
    .line_rd_char(line_rd_char), .pass(pass), .fail(fail), .done(done),
    .char_cnt(char_cnt), .line_cnt(line_cnt)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct { int len; bit trunc; bit p; bit f; } line_exp_t;
  line_exp_t  exp_q[$];
  logic [7:0] m_line[$];   // bytes stored for the line in progress
  logic [7:0] m_last[$];   // bytes of the last terminated line
  logic [7:0] m_seg[$];    // last few bytes since line start / CR
  int         m_cnt, m_chars, m_lines;
  bit         m_lp, m_lf, m_pass, m_fail;
  int         strobe_cnt = 0;
  int         n_popped   = 0;

  function automatic bit seg_ends_with(input string tok);
    if (m_seg.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_seg[m_seg.size() - 4 + i] != tok[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_line.delete(); m_seg.delete(); exp_q.delete();
    m_cnt = 0; m_chars = 0; m_lines = 0;
    m_lp = 0; m_lf = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    line_exp_t e;
    m_chars++;
    if (b == 8'h0A) begin
      m_pass  = m_pass | m_lp;
      m_fail  = m_fail | m_lf;
      e.len   = (m_cnt > LINE_MAX) ? LINE_MAX : m_cnt;
      e.trunc = (m_cnt > LINE_MAX);
      e.p     = m_pass;
      e.f     = m_fail;
      exp_q.push_back(e);
      m_last = m_line;
      m_line.delete(); m_seg.delete();
      m_cnt = 0; m_lp = 0; m_lf = 0;
      m_lines++;
    end else if (b == 8'h0D) begin
      m_seg.delete();
    end else begin
      if (m_cnt < LINE_MAX) m_line.push_back(b);
      m_cnt++;
      m_seg.push_back(b);
      if (m_seg.size() > 4) void'(m_seg.pop_front());
      if (seg_ends_with("PASS")) m_lp = 1;
      if (seg_ends_with("FAIL")) m_lf = 1;
    end
  endtask

  // --------------------------------------------------------------- monitors
  always @(negedge ACLK) begin
    if (rx_data_reg_rd === 1'b1) strobe_cnt++;
  end

  always @(negedge ACLK) begin
    line_exp_t e;
    if (line_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("line_valid_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("line_len",   32'(line_len),   32'(e.len));
        check_val("line_trunc", 32'(line_trunc), 32'(e.trunc));
        check_val("pass",       32'(pass),       32'(e.p));
        check_val("fail",       32'(fail),       32'(e.f));
        check_val("done",       32'(done),       32'(e.p | e.f));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    repeat ($urandom_range(0, 2)) @(negedge ACLK);
    @(negedge ACLK);
    rx_data  = b;
    rx_ready = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge ACLK);
      if (rx_data_reg_rd === 1'b1) got = 1;
    end
    rx_ready = 1'b0;
    check_val("pop_strobe", 32'(got), 32'd1);
    if (got) begin
      n_popped++;
      model_byte(b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(8'h0A);
  endtask

  task automatic wait_lines();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge ACLK);
    check_val("line_valid_seen", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic read_buf(input int idx, output logic [7:0] val);
    @(negedge ACLK);
    line_rd_idx = (LW-1)'(idx);
    @(negedge ACLK);
    val = line_rd_char;
  endtask

  task automatic check_reads(input int n);
    logic [7:0] v;
    int idx;
    if (m_last.size() == 0) return;
    repeat (n) begin
      idx = $urandom_range(0, m_last.size() - 1);
      read_buf(idx, v);
      check_val("buf_read", 32'(v), 32'(m_last[idx]));
    end
  endtask

  task automatic check_counters();
`ifdef UART_MON_CNT_EN
    check_val("char_cnt", char_cnt, 32'(m_chars));
    check_val("line_cnt", 32'(line_cnt), 32'(m_lines));
`else
    check_val("char_cnt", char_cnt, 32'd0);
    check_val("line_cnt", 32'(line_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset();
    ARESET   = 1'b1;
    rx_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    check_val("rst_strobe",     32'(rx_data_reg_rd), 32'd0);
    check_val("rst_line_valid", 32'(line_valid),     32'd0);
    check_val("rst_line_len",   32'(line_len),       32'd0);
    check_val("rst_line_trunc", 32'(line_trunc),     32'd0);
    check_val("rst_rd_char",    32'(line_rd_char),   32'd0);
    check_val("rst_done",       32'({pass, fail, done}), 32'd0);
    check_val("rst_char_cnt",   char_cnt,            32'd0);
    check_val("rst_line_cnt",   32'(line_cnt),       32'd0);
    ARESET = 1'b0;
    model_reset();
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    logic [7:0] v;
    int         s0;
    int         len;
    ARESET      = 1'b1;
    rx_ready    = 1'b0;
    rx_data     = 8'h00;
    line_rd_idx = '0;
    model_reset();
    do_reset();

    // Idle with nothing offered: no pop.
    s0 = strobe_cnt;
    repeat (5) @(negedge ACLK);
    check_val("idle_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Simple PASS line, 9 pops, buffer readback.
    s0 = strobe_cnt;
    send_line("Run PASS");
    wait_lines();
    check_val("run_pass_strobes", 32'(strobe_cnt - s0), 32'd9);
    read_buf(4, v);
    check_val("rd_idx4", 32'(v), 32'h50);
    check_reads(3);
    check_counters();

    // Mismatch restart plus CR before LF.
    do_reset();
    send_str("PAPASS");
    send_byte(8'h0D);
    send_byte(8'h0A);
    wait_lines();
    check_reads(2);

    // Two lines, both verdicts.
    do_reset();
    send_line("PASS");
    send_line("FAIL");
    wait_lines();
    check_counters();

    // Exactly full buffer, then overflow.
    do_reset();
    send_line({LINE_MAX{"B"}});
    wait_lines();
    check_reads(2);
    send_line({{70{"A"}}, "FAIL"});
    wait_lines();
    check_reads(3);

    // Reset one cycle after the pop of the final 'S' of "PAS".
    send_str("PA");
    send_byte("S");
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
    check_val("midrst_pass", 32'(pass),     32'(m_pass));
    check_val("midrst_fail", 32'(fail),     32'(m_fail));
    check_val("midrst_len",  32'(line_len), 32'(m_cnt));
    send_line("S");
    wait_lines();
    check_val("after_midrst_pass", 32'(pass), 32'd0);

    // Randomized lines.
    for (int l = 0; l < 24; l++) begin
      if (l % 6 == 0) do_reset();
      len = $urandom_range(0, 80);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 15))
          0:  send_byte("P");
          1:  send_byte("A");
          2:  send_byte("S");
          3:  send_byte("F");
          4:  send_byte("I");
          5:  send_byte("L");
          6:  send_byte(8'h0D);
          7:  send_str(($urandom_range(0, 1) == 1) ? "PASS" : "FAIL");
          default: send_byte(8'($urandom_range(32, 126)));
        endcase
      end
      send_byte(8'h0A);
      wait_lines();
      check_reads(2);
      check_counters();
    end

    check_val("total_strobes", 32'(strobe_cnt), 32'(n_popped));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_result_monitor.md
# uart_result_monitor

Simulation-side consumer of the byte stream recovered from the SoC's UART_TX line by the bench UART receiver. Pops each received byte, assembles it into a line buffer, and scans every line for the ASCII tokens "PASS" and "FAIL". It raises sticky verdict flags, so software-driven tests can end on a printed result instead of a fixed PC value. It sits directly downstream of the receiver and drives that receiver's read strobe.

## Interface
Parameters:
- LINE_MAX, 64: line buffer depth in bytes (power of two, 4..256)
- LW, $clog2(LINE_MAX)+1: width of line length/index fields

Ports:
- ACLK  in  1  clock; one clock domain, shared with the receiver
- ARESET  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid while rx_ready=1
- rx_ready  in  1  level: receiver holds an unread byte
- rx_data_reg_rd  out  1  one-cycle pop strobe to receiver
- line_valid  out  1  one-cycle pulse: line terminated
- line_len  out  LW  bytes stored in the last terminated line
- line_trunc  out  1  last terminated line exceeded LINE_MAX
- line_rd_idx  in  LW-1  buffer read address
- line_rd_char  out  8  buffer byte at line_rd_idx, registered
- pass  out  1  sticky: a line contained "PASS"
- fail  out  1  sticky: a line contained "FAIL"
- done  out  1  pass | fail
- char_cnt  out  32  total bytes popped (see Configuration)
- line_cnt  out  16  total lines terminated (see Configuration)

## Operation
- FSM states: IDLE, CAPT, PROC, EOL.
- IDLE: if rx_ready=1, go to CAPT.
- CAPT: rx_data_reg_rd=1; latch rx_data into byte_q; go to PROC.
- PROC, byte_q=0x0A (LF): go to EOL.
- PROC, byte_q=0x0D (CR): discard the byte; reset both matchers; go to IDLE.
- PROC, any other byte: if wr_ptr<LINE_MAX, write buf[wr_ptr] and increment wr_ptr. Otherwise set trunc_q and drop the byte. Update both matchers. Go to IDLE.
- EOL: line_valid=1, line_len<=wr_ptr, line_trunc<=trunc_q. Set pass/fail from the per-line hit flags. Clear wr_ptr, trunc_q, matchers and hit flags. Go to IDLE.
- Matcher, one per token: 3-bit idx. If the byte equals token[idx], then idx+1; otherwise idx<=(byte==token[0]) ? 1 : 0. Tokens have no self-overlap, so this is exact.
- Matcher completion: reaching idx=4 sets that token's hit flag and clears idx.
- Matchers keep running on dropped (truncated) bytes.
- Both tokens in one line: both pass and fail set; the bench treats fail as dominant.
- pass, fail and done clear only on ARESET.
- Buffer retention: contents remain readable after EOL until the next byte is stored, which overwrites buf[0].

## Timing
- Reset values: every output 0; FSM=IDLE; wr_ptr=0; all matchers and flags cleared. Buffer contents are not reset.
- ARESET asserted in any state forces IDLE on the next edge. A byte caught in CAPT/PROC is lost.
- Pop latency: rx_ready sampled high at edge N, then rx_data_reg_rd high for the cycle after N.
- Receiver contract: rx_ready must drop within one cycle of the strobe. The PROC cycle guards against a double pop.
- Throughput: at most 1 byte per 3 cycles (4 for LF), well above any UART rate.
- LF timing: line_valid, line_len and verdict flags all update on the same edge, the one leaving EOL.
- line_rd_char: 1-cycle read latency from line_rd_idx.
- Boundary, buffer full: exactly LINE_MAX bytes gives line_trunc=0. The (LINE_MAX+1)-th byte sets trunc_q.
- Boundary, empty line: a bare LF pulses line_valid with line_len=0.

## Configuration
- UART_MON_CNT_EN defined: char_cnt increments once per CAPT, and line_cnt once per EOL. Both wrap modulo 2^32 and 2^16 respectively.
- UART_MON_CNT_EN undefined: no counter registers; char_cnt and line_cnt tied to 0.

## Test plan
- Reset: hold ARESET 2 cycles, then release. All outputs are 0; no strobe with rx_ready=0.
- "Run PASS\n" (0x0A): 9 strobes; line_valid once with line_len=8. pass=1, fail=0, done=1; line_rd_idx=4 returns 0x50.
- "PAPASS\r\n": pass=1 (mismatch restart), line_len=6. The CR is not stored.
- "PASS\nFAIL\n": line_valid twice; pass=1 and fail=1; line_cnt=2 and char_cnt=10 with UART_MON_CNT_EN.
- 70 x 'A' then "FAIL\n" with LINE_MAX=64: line_len=64, line_trunc=1, fail=1.
- Assert ARESET one cycle after a strobe, mid-"PAS": all flags 0, FSM returns to IDLE. A following "S\n" gives pass=0 and line_len=1.
